// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared command codes, target constants and host FSM state for the JTAG host
// Contents:
//   CMD_*        command type codes on cmd_type
//   BYPASS       all-ones IR value selecting the 1-bit BYPASS register
//   IR_LEN       target instruction register width
//   LEN_W        width of cmd_len and the scan bit counter
//   host_state_e host FSM states
//   tms_for()    TMS level to present for the next TCK rise of a given phase
package jtag_pkg;

  localparam logic [1:0] CMD_TAP_RESET = 2'd0;
  localparam logic [1:0] CMD_SHIFT_IR  = 2'd1;
  localparam logic [1:0] CMD_SHIFT_DR  = 2'd2;
  localparam logic [1:0] CMD_RUN_IDLE  = 2'd3;

  localparam logic [3:0] BYPASS = 4'hF;
  localparam int         IR_LEN = 4;
  localparam int         LEN_W  = 6;

  typedef enum logic [2:0] {
    HOST_IDLE,
    TLR_SEQ,
    SEL,
    CAP,
    SHIFT,
    EXIT_UPD,
    DONE
  } host_state_e;

  // step counts edges within TLR_SEQ (0..5) and EXIT_UPD (0..1).
  function automatic logic tms_for(host_state_e st, logic [2:0] step, logic last_bit,
                                   logic is_run);
    logic tms;
    tms = 1'b0;
    case (st)
      TLR_SEQ:  tms = (step != 3'd5);
      SEL:      tms = 1'b1;
      SHIFT:    tms = last_bit && !is_run;
      EXIT_UPD: tms = (step == 3'd0);
      default:  tms = 1'b0;
    endcase
    return tms;
  endfunction

endpackage

// File: rtl/jtag_host_tck_gen.sv
// rtl/jtag_host_tck_gen.sv - TCK divider with rise/fall strobes and enable
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   en_i        run TCK; when low TCK is forced low and strobes are suppressed
//   tck_o       divided clock, CLK_DIV clk cycles per half period, low after enable
//   rise_o      high in the clk cycle whose closing edge raises tck_o
//   fall_o      high in the clk cycle whose closing edge lowers tck_o
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tck_q, tck_d;
  logic             cnt_last;

  always_comb begin
    cnt_last = (cnt_q == CNT_W'(CLK_DIV - 1));
    rise_o   = en_i && !tck_q && cnt_last;
    fall_o   = en_i &&  tck_q && cnt_last;
    cnt_d    = '0;
    tck_d    = 1'b0;
    if (en_i) begin
      cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
      tck_d = cnt_last ? ~tck_q : tck_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o = tck_q;

endmodule

// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - host-side JTAG driver walking a target TAP through IR/DR scans
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; ready only while idle
//   cmd_type             0 TAP_RESET, 1 SHIFT_IR, 2 SHIFT_DR, 3 RUN_IDLE
//   cmd_len              scan bits or idle TCK cycles (clamped to MAX_LEN)
//   cmd_data             TDI bits, LSB shifted first
//   rsp_valid            one-cycle completion pulse
//   rsp_data             captured TDO bits, bit i = i-th shifted bit
//   tck_o/tms_o/tdi_o    JTAG drive to target
//   tdo_i                JTAG TDO from target (changes on TCK fall)
//   trst_o               active-high target TAP reset
module jtag_host
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output logic               trst_o
);

  host_state_e        state_q, state_d;
  logic [2:0]         step_q, step_d;
  logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]   len_q, len_d, len_clamped;
  logic [1:0]         type_q, type_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_q, trst_d;
  logic               known_q, known_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               tck_en, tck_rise, tck_fall;
  logic               start_main, upd_pins;

  assign tck_en = (state_q != HOST_IDLE);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (tck_en),
    .tck_o  (tck_o),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    bit_cnt_d   = bit_cnt_q;
    len_d       = len_q;
    type_d      = type_q;
    data_d      = data_q;
    cap_d       = cap_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_d      = trst_q;
    known_d     = known_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    start_main  = 1'b0;
    upd_pins    = 1'b0;
    len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;

    // Phase advances happen on TCK rise strobes; pin updates on fall strobes.
    case (state_q)
      HOST_IDLE: begin
        if (cmd_valid) begin
          type_d = cmd_type;
          len_d  = len_clamped;
          data_d = cmd_data;
          cap_d  = '0;
          if (cmd_type != CMD_TAP_RESET && len_clamped == '0) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end else if (cmd_type == CMD_TAP_RESET || !known_q) begin
            state_d  = TLR_SEQ;
            step_d   = 3'd0;
            trst_d   = (cmd_type == CMD_TAP_RESET);
            upd_pins = 1'b1;
          end else begin
            start_main = 1'b1;
            upd_pins   = 1'b1;
          end
        end
      end
      TLR_SEQ: begin
        if (tck_rise) begin
          if (step_q == 3'd5) begin
            known_d = 1'b1;
            if (type_q == CMD_TAP_RESET) state_d = DONE;
            else                         start_main = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      SEL: begin
        // IR path needs Select-DR then Select-IR; DR path only Select-DR.
        if (tck_rise) begin
          if (type_q == CMD_SHIFT_IR && step_q == 3'd0) begin
            step_d = 3'd1;
          end else begin
            state_d = CAP;
            step_d  = 3'd0;
          end
        end
      end
      CAP: begin
        if (tck_rise) begin
          if (step_q == 3'd0) begin
            step_d = 3'd1;
          end else begin
            state_d   = SHIFT;
            bit_cnt_d = len_q - LEN_W'(1);
          end
        end
      end
      SHIFT: begin
        if (tck_rise) begin
          if (type_q != CMD_RUN_IDLE) begin
            cap_d  = cap_q | ({{(MAX_LEN-1){1'b0}}, tdo_i} << (len_q - LEN_W'(1) - bit_cnt_q));
            data_d = data_q >> 1;
          end
          if (bit_cnt_q == '0) begin
            state_d = (type_q == CMD_RUN_IDLE) ? DONE : EXIT_UPD;
            step_d  = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q - LEN_W'(1);
          end
        end
      end
      EXIT_UPD: begin
        if (tck_rise) begin
          if (step_q == 3'd0) step_d = 3'd1;
          else                state_d = DONE;
        end
      end
      DONE: begin
        if (tck_fall) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
          state_d     = HOST_IDLE;
        end
      end
      default: state_d = HOST_IDLE;
    endcase

    if (start_main) begin
      if (type_d == CMD_RUN_IDLE) begin
        state_d   = SHIFT;
        bit_cnt_d = len_d - LEN_W'(1);
      end else begin
        state_d = SEL;
        step_d  = 3'd0;
      end
    end

    // TMS/TDI for the coming rise: set at accept (TCK still low) or on a fall.
    if (upd_pins || tck_fall) begin
      tms_d = tms_for(state_d, step_d, (bit_cnt_d == '0), (type_d == CMD_RUN_IDLE));
      tdi_d = (state_d == SHIFT && type_d != CMD_RUN_IDLE) ? data_d[0] : 1'b0;
    end

    // TRST spans exactly the first TCK period of a TAP_RESET.
    if (tck_fall) trst_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOST_IDLE;
      step_q      <= 3'd0;
      bit_cnt_q   <= '0;
      len_q       <= '0;
      type_q      <= CMD_TAP_RESET;
      data_q      <= '0;
      cap_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b0;
      known_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      bit_cnt_q   <= bit_cnt_d;
      len_q       <= len_d;
      type_q      <= type_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_q      <= trst_d;
      known_q     <= known_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == HOST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tms_o     = tms_q;
  assign tdi_o     = tdi_q;
  assign trst_o    = trst_q;

endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - directed self-checking bench for jtag_host against a behavioural TAP
module tb_jtag_host;
  import jtag_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tck_o, tms_o, tdi_o, trst_o;
  logic        tdo_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int trst_cnt = 0;
  bit tms_log[$];
  bit tdi_log[$];

  always #5 clk = ~clk;

  jtag_host #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tck_o     (tck_o),
    .tms_o     (tms_o),
    .tdi_o     (tdi_o),
    .tdo_i     (tdo_i),
    .trst_o    (trst_o)
  );

  // Behavioural target TAP: 4-bit IR (capture loads current IR), 1-bit BYPASS DR.
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UP_DR,
    T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UP_IR
  } tap_e;

  tap_e              tap = T_TLR;
  logic [IR_LEN-1:0] ir = BYPASS;
  logic [IR_LEN-1:0] ir_sr = '0;
  logic              bp = 1'b0;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      T_TLR:    return tms ? T_TLR    : T_RTI;
      T_RTI:    return tms ? T_SEL_DR : T_RTI;
      T_SEL_DR: return tms ? T_SEL_IR : T_CAP_DR;
      T_CAP_DR: return tms ? T_EX1_DR : T_SH_DR;
      T_SH_DR:  return tms ? T_EX1_DR : T_SH_DR;
      T_EX1_DR: return tms ? T_UP_DR  : T_PA_DR;
      T_PA_DR:  return tms ? T_EX2_DR : T_PA_DR;
      T_EX2_DR: return tms ? T_UP_DR  : T_SH_DR;
      T_UP_DR:  return tms ? T_SEL_DR : T_RTI;
      T_SEL_IR: return tms ? T_TLR    : T_CAP_IR;
      T_CAP_IR: return tms ? T_EX1_IR : T_SH_IR;
      T_SH_IR:  return tms ? T_EX1_IR : T_SH_IR;
      T_EX1_IR: return tms ? T_UP_IR  : T_PA_IR;
      T_PA_IR:  return tms ? T_EX2_IR : T_PA_IR;
      T_EX2_IR: return tms ? T_UP_IR  : T_SH_IR;
      default:  return tms ? T_SEL_DR : T_RTI;
    endcase
  endfunction

  always @(posedge tck_o or posedge trst_o) begin
    if (trst_o) begin
      tap <= T_TLR;
      ir  <= BYPASS;
    end else begin
      case (tap)
        T_TLR:    ir    <= BYPASS;
        T_CAP_IR: ir_sr <= ir;
        T_SH_IR:  ir_sr <= {tdi_o, ir_sr[IR_LEN-1:1]};
        T_UP_IR:  ir    <= ir_sr;
        T_CAP_DR: bp    <= 1'b0;
        T_SH_DR:  bp    <= tdi_o;
        default:  ;
      endcase
      tap <= tap_next(tap, tms_o);
    end
  end

  always @(negedge tck_o) begin
    tdo_i <= (tap == T_SH_IR) ? ir_sr[0] : (tap == T_SH_DR) ? bp : 1'b0;
  end

  // Pin log: every TCK rise, including those while TRST holds the TAP.
  always @(posedge tck_o) begin
    tms_log.push_back(tms_o);
    if (tap == T_SH_IR) tdi_log.push_back(tdi_o);
  end

  always @(negedge clk) if (trst_o) trst_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_bits(input bit q[$]);
    logic [31:0] v;
    v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  task automatic run_cmd(input string tag, input logic [1:0] t, input logic [5:0] l,
                         input logic [31:0] d, output logic [31:0] rsp, output int cyc,
                         output logic rdy_after);
    @(negedge clk);
    tms_log.delete();
    tdi_log.delete();
    trst_cnt  = 0;
    cmd_type  = t;
    cmd_len   = l;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rdy_after = cmd_ready;
    cyc = 1;
    while (!rsp_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_rsp_seen"}, {31'd0, rsp_valid}, 32'd1);
    rsp = rsp_data;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          cyc;
    int          n_rsp;
    logic        rdy;

    repeat (3) @(negedge clk);
    check_eq("rst_tck",       {31'd0, tck_o},     32'd0);
    check_eq("rst_tms",       {31'd0, tms_o},     32'd1);
    check_eq("rst_tdi",       {31'd0, tdi_o},     32'd0);
    check_eq("rst_trst",      {31'd0, trst_o},    32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_data",  rsp_data,           32'd0);
    check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rst_n = 1'b1;

    run_cmd("tr", CMD_TAP_RESET, 6'd0, 32'd0, r, cyc, rdy);
    check_eq("tr_ready_drop", {31'd0, rdy},         32'd0);
    check_eq("tr_trst_clks",  trst_cnt,             32'd4);
    check_eq("tr_rises",      tms_log.size(),       32'd6);
    check_eq("tr_tms",        pack_bits(tms_log),   32'b111110);
    check_eq("tr_rsp",        r,                    32'd0);

    run_cmd("ir5", CMD_SHIFT_IR, 6'd4, 32'h5, r, cyc, rdy);
    check_eq("ir5_rises", tms_log.size(),     32'd10);
    check_eq("ir5_tms",   pack_bits(tms_log), 32'b1100000110);
    check_eq("ir5_tdi",   pack_bits(tdi_log), 32'b1010);
    check_eq("ir5_trst",  trst_cnt,           32'd0);
    check_eq("ir5_rsp",   r,                  32'hF);

    run_cmd("ira", CMD_SHIFT_IR, 6'd4, 32'hA, r, cyc, rdy);
    check_eq("ira_tdi", pack_bits(tdi_log), 32'b0101);
    check_eq("ira_rsp", r,                  32'h5);

    run_cmd("dr32", CMD_SHIFT_DR, 6'd32, 32'hDEADBEEF, r, cyc, rdy);
    check_eq("dr32_rises", tms_log.size(), 32'd37);
    check_eq("dr32_rsp",   r,              32'hBD5B7DDE);

    run_cmd("dr0", CMD_SHIFT_DR, 6'd0, 32'hFFFFFFFF, r, cyc, rdy);
    check_eq("dr0_latency", cyc,            32'd1);
    check_eq("dr0_rises",   tms_log.size(), 32'd0);
    check_eq("dr0_rsp",     r,              32'd0);

    run_cmd("dr40", CMD_SHIFT_DR, 6'd40, 32'h12345678, r, cyc, rdy);
    check_eq("dr40_rises", tms_log.size(), 32'd37);
    check_eq("dr40_rsp",   r,              32'h2468ACF0);

    run_cmd("rti5", CMD_RUN_IDLE, 6'd5, 32'hFFFFFFFF, r, cyc, rdy);
    check_eq("rti5_rises", tms_log.size(),     32'd5);
    check_eq("rti5_tms",   pack_bits(tms_log), 32'd0);
    check_eq("rti5_rsp",   r,                  32'd0);

    @(negedge clk);
    tms_log.delete();
    cmd_type  = CMD_SHIFT_DR;
    cmd_len   = 6'd32;
    cmd_data  = 32'hFFFF0000;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (tms_log.size() < 13 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("mid_reach_bit10", tms_log.size(), 32'd13);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_tck",       {31'd0, tck_o},     32'd0);
    check_eq("mid_tms",       {31'd0, tms_o},     32'd1);
    check_eq("mid_trst",      {31'd0, trst_o},    32'd0);
    check_eq("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    check_eq("mid_no_rsp", n_rsp, 32'd0);

    run_cmd("rec", CMD_SHIFT_IR, 6'd4, 32'h3, r, cyc, rdy);
    check_eq("rec_rises", tms_log.size(),     32'd16);
    check_eq("rec_tms",   pack_bits(tms_log), 32'hFB06);
    check_eq("rec_tdi",   pack_bits(tdi_log), 32'b1100);
    check_eq("rec_trst",  trst_cnt,           32'd0);
    check_eq("rec_rsp",   r,                  32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
